// File: rtl/issue_queue_int.sv
// rtl/issue_queue_int.sv - 4-entry integer issue queue with CDB wakeup and select
//
// Optional feature macro: ISSUEQ_OLDEST_FIRST_EN
//   defined   -> per-entry 2-bit age rank, oldest issuable entry is selected
//   undefined -> no age storage, lowest-index issuable entry is selected

module issue_queue_int (
    input  logic        clock,
    input  logic        reset,
    input  logic        dispatch_en_integer,
    input  logic [3:0]  dispatch_opcode,
    input  logic [4:0]  dispatch_shfamt,
    input  logic [4:0]  dispatch_rd_tag,
    input  logic [31:0] dispatch_rs_data,
    input  logic [31:0] dispatch_rt_data,
    input  logic        dispatch_rs_data_valid,
    input  logic        dispatch_rt_data_valid,
    input  logic [4:0]  dispatch_rs_tag,
    input  logic [4:0]  dispatch_rt_tag,
    output logic        issueque_integer_full,
    input  logic        cdb_valid,
    input  logic [4:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        flush,
    input  logic        issue_ready,
    output logic        issue_valid,
    output logic [3:0]  issue_opcode,
    output logic [4:0]  issue_shfamt,
    output logic [31:0] issue_rs_data,
    output logic [31:0] issue_rt_data,
    output logic [4:0]  issue_rd_tag
);

    localparam int DEPTH = 4;

    // Entry storage
    logic [DEPTH-1:0] valid_q,  valid_d;
    logic [3:0]       opcode_q  [DEPTH];
    logic [3:0]       opcode_d  [DEPTH];
    logic [4:0]       shfamt_q  [DEPTH];
    logic [4:0]       shfamt_d  [DEPTH];
    logic [4:0]       rd_tag_q  [DEPTH];
    logic [4:0]       rd_tag_d  [DEPTH];
    logic [31:0]      rs_data_q [DEPTH];
    logic [31:0]      rs_data_d [DEPTH];
    logic [31:0]      rt_data_q [DEPTH];
    logic [31:0]      rt_data_d [DEPTH];
    logic [DEPTH-1:0] rs_rdy_q, rs_rdy_d;
    logic [DEPTH-1:0] rt_rdy_q, rt_rdy_d;
    logic [4:0]       rs_tag_q  [DEPTH];
    logic [4:0]       rs_tag_d  [DEPTH];
    logic [4:0]       rt_tag_q  [DEPTH];
    logic [4:0]       rt_tag_d  [DEPTH];
`ifdef ISSUEQ_OLDEST_FIRST_EN
    logic [1:0]       age_q     [DEPTH];
    logic [1:0]       age_d     [DEPTH];
    logic [1:0]       best_rank;
    logic [2:0]       n_valid;
    logic [1:0]       new_rank;
`endif

    logic [DEPTH-1:0] issuable;
    logic             issue_any;
    logic [1:0]       sel_idx;
    logic             issue_fire;
    logic [1:0]       free_idx;
    logic             dispatch_ok;

    logic             disp_rs_rdy, disp_rt_rdy;
    logic [31:0]      disp_rs_val, disp_rt_val;

    assign issueque_integer_full = &valid_q;
    assign issuable              = valid_q & rs_rdy_q & rt_rdy_q;
    assign issue_fire            = issue_any & issue_ready;
    assign dispatch_ok           = dispatch_en_integer & ~issueque_integer_full;

    // Select one issuable entry: oldest rank, or lowest index
    always_comb begin
        issue_any = 1'b0;
        sel_idx   = 2'd0;
`ifdef ISSUEQ_OLDEST_FIRST_EN
        best_rank = 2'd3;
        for (int i = 0; i < DEPTH; i++) begin
            if (issuable[i] && (!issue_any || age_q[i] < best_rank)) begin
                issue_any = 1'b1;
                sel_idx   = 2'(i);
                best_rank = age_q[i];
            end
        end
`else
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (issuable[i]) begin
                issue_any = 1'b1;
                sel_idx   = 2'(i);
            end
        end
`endif
    end

    // Lowest-index free slot, taken from registered state only
    always_comb begin
        free_idx = 2'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = 2'(i);
        end
    end

    // Dispatch operand resolution, including same-cycle CDB bypass
    always_comb begin
        disp_rs_rdy = dispatch_rs_data_valid;
        disp_rs_val = dispatch_rs_data;
        if (!dispatch_rs_data_valid) begin
            disp_rs_val = 32'd0;
            if (cdb_valid && cdb_tag == dispatch_rs_tag) begin
                disp_rs_rdy = 1'b1;
                disp_rs_val = cdb_data;
            end
        end
        disp_rt_rdy = dispatch_rt_data_valid;
        disp_rt_val = dispatch_rt_data;
        if (!dispatch_rt_data_valid) begin
            disp_rt_val = 32'd0;
            if (cdb_valid && cdb_tag == dispatch_rt_tag) begin
                disp_rt_rdy = 1'b1;
                disp_rt_val = cdb_data;
            end
        end
    end

`ifdef ISSUEQ_OLDEST_FIRST_EN
    // Rank for a new entry; an entry leaving on the same edge shifts the ranks down
    always_comb begin
        n_valid = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            n_valid = n_valid + {2'b00, valid_q[i]};
        end
        new_rank = 2'(n_valid - {2'b00, issue_fire});
    end
`endif

    // Next-state: wakeup, issue free, dispatch write, then flush overrides
    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        shfamt_d  = shfamt_q;
        rd_tag_d  = rd_tag_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        rs_rdy_d  = rs_rdy_q;
        rt_rdy_d  = rt_rdy_q;
        rs_tag_d  = rs_tag_q;
        rt_tag_d  = rt_tag_q;
`ifdef ISSUEQ_OLDEST_FIRST_EN
        age_d     = age_q;
`endif

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && valid_q[i]) begin
                if (!rs_rdy_q[i] && rs_tag_q[i] == cdb_tag) begin
                    rs_rdy_d[i]  = 1'b1;
                    rs_data_d[i] = cdb_data;
                end
                if (!rt_rdy_q[i] && rt_tag_q[i] == cdb_tag) begin
                    rt_rdy_d[i]  = 1'b1;
                    rt_data_d[i] = cdb_data;
                end
            end
        end

        if (issue_fire) begin
            valid_d[sel_idx] = 1'b0;
`ifdef ISSUEQ_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && age_q[i] > age_q[sel_idx]) begin
                    age_d[i] = age_q[i] - 2'd1;
                end
            end
`endif
        end

        // The free slot is never the selected one, so no slot is reused in one edge
        if (dispatch_ok) begin
            valid_d[free_idx]   = 1'b1;
            opcode_d[free_idx]  = dispatch_opcode;
            shfamt_d[free_idx]  = dispatch_shfamt;
            rd_tag_d[free_idx]  = dispatch_rd_tag;
            rs_data_d[free_idx] = disp_rs_val;
            rt_data_d[free_idx] = disp_rt_val;
            rs_rdy_d[free_idx]  = disp_rs_rdy;
            rt_rdy_d[free_idx]  = disp_rt_rdy;
            rs_tag_d[free_idx]  = dispatch_rs_tag;
            rt_tag_d[free_idx]  = dispatch_rt_tag;
`ifdef ISSUEQ_OLDEST_FIRST_EN
            age_d[free_idx]     = new_rank;
`endif
        end

        if (flush) begin
            valid_d = '0;
`ifdef ISSUEQ_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++) age_d[i] = 2'd0;
`endif
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            rs_rdy_q <= '0;
            rt_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_q[i]  <= 4'd0;
                shfamt_q[i]  <= 5'd0;
                rd_tag_q[i]  <= 5'd0;
                rs_data_q[i] <= 32'd0;
                rt_data_q[i] <= 32'd0;
                rs_tag_q[i]  <= 5'd0;
                rt_tag_q[i]  <= 5'd0;
`ifdef ISSUEQ_OLDEST_FIRST_EN
                age_q[i]     <= 2'd0;
`endif
            end
        end else begin
            valid_q   <= valid_d;
            rs_rdy_q  <= rs_rdy_d;
            rt_rdy_q  <= rt_rdy_d;
            opcode_q  <= opcode_d;
            shfamt_q  <= shfamt_d;
            rd_tag_q  <= rd_tag_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rs_tag_q  <= rs_tag_d;
            rt_tag_q  <= rt_tag_d;
`ifdef ISSUEQ_OLDEST_FIRST_EN
            age_q     <= age_d;
`endif
        end
    end

    assign issue_valid   = issue_any;
    assign issue_opcode  = issue_any ? opcode_q[sel_idx]  : 4'd0;
    assign issue_shfamt  = issue_any ? shfamt_q[sel_idx]  : 5'd0;
    assign issue_rs_data = issue_any ? rs_data_q[sel_idx] : 32'd0;
    assign issue_rt_data = issue_any ? rt_data_q[sel_idx] : 32'd0;
    assign issue_rd_tag  = issue_any ? rd_tag_q[sel_idx]  : 5'd0;

endmodule

// File: tb/tb_issue_queue_int.sv
// tb/tb_issue_queue_int.sv - directed self-checking bench for issue_queue_int

module tb_issue_queue_int;

    logic        clock = 1'b0;
    logic        reset;
    logic        dispatch_en_integer;
    logic [3:0]  dispatch_opcode;
    logic [4:0]  dispatch_shfamt;
    logic [4:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs_data;
    logic [31:0] dispatch_rt_data;
    logic        dispatch_rs_data_valid;
    logic        dispatch_rt_data_valid;
    logic [4:0]  dispatch_rs_tag;
    logic [4:0]  dispatch_rt_tag;
    logic        issueque_integer_full;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic        issue_ready;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [4:0]  issue_shfamt;
    logic [31:0] issue_rs_data;
    logic [31:0] issue_rt_data;
    logic [4:0]  issue_rd_tag;

    int checks = 0;
    int errors = 0;

    issue_queue_int dut (
        .clock                  (clock),
        .reset                  (reset),
        .dispatch_en_integer    (dispatch_en_integer),
        .dispatch_opcode        (dispatch_opcode),
        .dispatch_shfamt        (dispatch_shfamt),
        .dispatch_rd_tag        (dispatch_rd_tag),
        .dispatch_rs_data       (dispatch_rs_data),
        .dispatch_rt_data       (dispatch_rt_data),
        .dispatch_rs_data_valid (dispatch_rs_data_valid),
        .dispatch_rt_data_valid (dispatch_rt_data_valid),
        .dispatch_rs_tag        (dispatch_rs_tag),
        .dispatch_rt_tag        (dispatch_rt_tag),
        .issueque_integer_full  (issueque_integer_full),
        .cdb_valid              (cdb_valid),
        .cdb_tag                (cdb_tag),
        .cdb_data               (cdb_data),
        .flush                  (flush),
        .issue_ready            (issue_ready),
        .issue_valid            (issue_valid),
        .issue_opcode           (issue_opcode),
        .issue_shfamt           (issue_shfamt),
        .issue_rs_data          (issue_rs_data),
        .issue_rt_data          (issue_rt_data),
        .issue_rd_tag           (issue_rd_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic disp(input logic [4:0] rd, input logic rs_v, input logic [31:0] rs,
                        input logic [4:0] rs_t, input logic rt_v, input logic [31:0] rt,
                        input logic [4:0] rt_t);
        dispatch_en_integer    = 1'b1;
        dispatch_opcode        = 4'd1;
        dispatch_shfamt        = 5'd2;
        dispatch_rd_tag        = rd;
        dispatch_rs_data_valid = rs_v;
        dispatch_rs_data       = rs;
        dispatch_rs_tag        = rs_t;
        dispatch_rt_data_valid = rt_v;
        dispatch_rt_data       = rt;
        dispatch_rt_tag        = rt_t;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic idle();
        dispatch_en_integer = 1'b0;
        cdb_valid           = 1'b0;
        flush               = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        issue_ready = 1'b0;
        disp(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0);
        dispatch_en_integer = 1'b0;
        cdb_tag  = 5'd0;
        cdb_data = 32'd0;
        #12;
        check("reset_full", {31'd0, issueque_integer_full}, 32'd0);
        check("reset_issue_valid", {31'd0, issue_valid}, 32'd0);
        check("reset_rd_tag", {27'd0, issue_rd_tag}, 32'd0);
        check("reset_rs_data", issue_rs_data, 32'd0);
        reset = 1'b1;
        step();

        // Single ready dispatch issues the next cycle
        disp(5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
        step();
        idle();
        check("basic_valid", {31'd0, issue_valid}, 32'd1);
        check("basic_rd_tag", {27'd0, issue_rd_tag}, 32'd3);
        check("basic_rs", issue_rs_data, 32'd5);
        check("basic_rt", issue_rt_data, 32'd7);
        check("basic_opcode", {28'd0, issue_opcode}, 32'd1);
        check("basic_shfamt", {27'd0, issue_shfamt}, 32'd2);
        issue_ready = 1'b1;
        step();
        check("basic_freed", {31'd0, issue_valid}, 32'd0);

        // Fill with four waiting entries
        for (int k = 1; k <= 4; k++) begin
            disp(5'(k), 1'b0, 32'd0, 5'd9, 1'b1, 32'd100, 5'd0);
            step();
        end
        check("fill_full", {31'd0, issueque_integer_full}, 32'd1);
        check("fill_no_issue", {31'd0, issue_valid}, 32'd0);
        disp(5'd10, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        step();
        idle();
        check("fifth_ignored_full", {31'd0, issueque_integer_full}, 32'd1);
        check("fifth_ignored_nv", {31'd0, issue_valid}, 32'd0);
        issue_ready = 1'b0;
        cdb(5'd9, 32'h1234);
        step();
        idle();
        check("wake_valid", {31'd0, issue_valid}, 32'd1);
        check("wake_rs", issue_rs_data, 32'h1234);
        check("wake_rd", {27'd0, issue_rd_tag}, 32'd1);

        // Issue plus dispatch while full: dispatch must be dropped
        issue_ready = 1'b1;
        disp(5'd20, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        step();
        idle();
        check("full_race_full", {31'd0, issueque_integer_full}, 32'd0);
        check("drain_rd2", {27'd0, issue_rd_tag}, 32'd2);
        step();
        check("drain_rd3", {27'd0, issue_rd_tag}, 32'd3);
        step();
        check("drain_rd4", {27'd0, issue_rd_tag}, 32'd4);
        step();
        check("drain_empty", {31'd0, issue_valid}, 32'd0);
        issue_ready = 1'b0;

        // Same-cycle CDB bypass at dispatch
        disp(5'd6, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd12);
        cdb(5'd12, 32'hAA);
        step();
        idle();
        check("bypass_valid", {31'd0, issue_valid}, 32'd1);
        check("bypass_rt", issue_rt_data, 32'hAA);
        check("bypass_rd", {27'd0, issue_rd_tag}, 32'd6);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("bypass_freed", {31'd0, issue_valid}, 32'd0);

        // Build: index 2 older (rd 13) and index 0 newer (rd 14), both ready
        disp(5'd11, 1'b0, 32'd0, 5'd20, 1'b1, 32'd0, 5'd0);
        step();
        disp(5'd12, 1'b0, 32'd0, 5'd21, 1'b1, 32'd0, 5'd0);
        step();
        disp(5'd13, 1'b0, 32'd0, 5'd22, 1'b1, 32'd0, 5'd0);
        step();
        idle();
        cdb(5'd20, 32'd0);
        step();
        idle();
        check("age_first_rd11", {27'd0, issue_rd_tag}, 32'd11);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("age_none_ready", {31'd0, issue_valid}, 32'd0);
        disp(5'd14, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
        cdb(5'd22, 32'd0);
        step();
        idle();
`ifdef ISSUEQ_OLDEST_FIRST_EN
        check("order_first", {27'd0, issue_rd_tag}, 32'd13);
`else
        check("order_first", {27'd0, issue_rd_tag}, 32'd14);
`endif
        issue_ready = 1'b1;
        step();
`ifdef ISSUEQ_OLDEST_FIRST_EN
        check("order_second", {27'd0, issue_rd_tag}, 32'd14);
`else
        check("order_second", {27'd0, issue_rd_tag}, 32'd13);
`endif
        step();
        issue_ready = 1'b0;
        check("order_done", {31'd0, issue_valid}, 32'd0);

        // Flush with three entries and a concurrent dispatch
        disp(5'd15, 1'b0, 32'd0, 5'd25, 1'b1, 32'd0, 5'd0);
        step();
        disp(5'd16, 1'b0, 32'd0, 5'd25, 1'b1, 32'd0, 5'd0);
        step();
        idle();
        check("pre_flush_full", {31'd0, issueque_integer_full}, 32'd0);
        flush = 1'b1;
        disp(5'd30, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        step();
        idle();
        check("flush_full", {31'd0, issueque_integer_full}, 32'd0);
        check("flush_nv", {31'd0, issue_valid}, 32'd0);
        cdb(5'd25, 32'd0);
        step();
        idle();
        check("flush_no_wake25", {31'd0, issue_valid}, 32'd0);
        cdb(5'd21, 32'd0);
        step();
        idle();
        check("flush_no_wake21", {31'd0, issue_valid}, 32'd0);

        // Asynchronous reset between edges with two ready entries
        disp(5'd7, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        step();
        disp(5'd8, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        step();
        idle();
        check("prereset_valid", {31'd0, issue_valid}, 32'd1);
        issue_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_nv", {31'd0, issue_valid}, 32'd0);
        check("async_reset_rd", {27'd0, issue_rd_tag}, 32'd0);
        #1;
        reset = 1'b1;
        step();
        check("post_release_nv", {31'd0, issue_valid}, 32'd0);
        check("post_release_full", {31'd0, issueque_integer_full}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
